voq_sched_ctrl: RTL

- Per-slot crossbar scheduler for the 4x4 switch.
- On each scheduling request it walks the 4 ingress ports sequentially, one per cycle.
- Each ingress takes the first non-empty VOQ whose egress is not yet claimed, scanning in round-robin order from that ingress's egress pointer.
- Produces a conflict-free ingress->egress match consumed by the crossbar/packet-transfer logic; rotates ingress and egress priorities between rounds for fairness.

---
 rtl/voq_sched_if.sv | 22 ++
 rtl/voq_sched_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/voq_sched_if.sv
// Request/result bundle between the VOQ scheduler and its requester.
// The master side issues scheduling requests and reads back the match;
// the slave side is the scheduler itself.
interface voq_sched_if;
  logic        sched_start;
  logic [15:0] voq_empty;
  logic        busy;
  logic        sched_valid;
  logic [3:0]  grant_valid;
  logic [7:0]  grant_egress;
  logic [3:0]  egress_taken;

  modport master (
    output sched_start, voq_empty,
    input  busy, sched_valid, grant_valid, grant_egress, egress_taken
  );

  modport slave (
    input  sched_start, voq_empty,
    output busy, sched_valid, grant_valid, grant_egress, egress_taken
  );
endinterface

// File: rtl/voq_sched_ctrl.sv
// Per-slot crossbar scheduler for a 4x4 VOQ switch.
// Each round visits the four ingresses one per cycle, starting from a rotating
// ingress pointer. Every ingress claims the first non-empty VOQ whose egress is
// still free, scanning from its own rotating egress pointer. Pointers advance
// after each round so that both ingress and egress priorities rotate.
module voq_sched_ctrl #(
  parameter int N_PORT = 4
) (
  input logic       clk,
  input logic       reset_n,
  voq_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PICK, DONE} state_t;

  state_t              state_q;
  logic [1:0]          step_q;
  logic [1:0]          inPtr_q;
  logic [1:0]          egPtr_q [N_PORT];
  logic [15:0]         emptyMask_q;
  logic                busy_q;
  logic                schedValid_q;
  logic [N_PORT-1:0]   grantValid_q;
  logic [2*N_PORT-1:0] grantEgress_q;
  logic [N_PORT-1:0]   egressTaken_q;

  logic [1:0] pickIng;
  logic [1:0] pickCand;
  logic       pickFound_d;
  logic [1:0] pickEgress_d;

  // Round-robin egress search for the ingress served in the current step.
  always_comb begin
    pickIng      = inPtr_q + step_q;
    pickCand     = 2'd0;
    pickFound_d  = 1'b0;
    pickEgress_d = 2'd0;
    for (int k = 0; k < N_PORT; k++) begin
      pickCand = egPtr_q[pickIng] + 2'(k);
      if (!pickFound_d && !emptyMask_q[{pickIng, pickCand}] && !egressTaken_q[pickCand]) begin
        pickFound_d  = 1'b1;
        pickEgress_d = pickCand;
      end
    end
  end

  // Scheduler FSM: latch request, walk ingresses, publish match, rotate pointers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      step_q        <= 2'd0;
      inPtr_q       <= 2'd0;
      for (int i = 0; i < N_PORT; i++) egPtr_q[i] <= 2'd0;
      emptyMask_q   <= 16'd0;
      busy_q        <= 1'b0;
      schedValid_q  <= 1'b0;
      grantValid_q  <= '0;
      grantEgress_q <= '0;
      egressTaken_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.sched_start) begin
            emptyMask_q   <= bus.voq_empty;
            step_q        <= 2'd0;
            grantValid_q  <= '0;
            grantEgress_q <= '0;
            egressTaken_q <= '0;
            busy_q        <= 1'b1;
            state_q       <= PICK;
          end
        end
        PICK: begin
          if (pickFound_d) begin
            grantValid_q[pickIng]                <= 1'b1;
            grantEgress_q[{pickIng, 1'b0} +: 2]  <= pickEgress_d;
            egressTaken_q[pickEgress_d]          <= 1'b1;
          end
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            schedValid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          schedValid_q <= 1'b0;
          busy_q       <= 1'b0;
          inPtr_q      <= inPtr_q + 2'd1;
          for (int i = 0; i < N_PORT; i++) begin
            if (grantValid_q[i]) egPtr_q[i] <= grantEgress_q[2*i +: 2] + 2'd1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.sched_valid  = schedValid_q;
  assign bus.grant_valid  = grantValid_q;
  assign bus.grant_egress = grantEgress_q;
  assign bus.egress_taken = egressTaken_q;

endmodule
